jpeg_idct_transpose_ctrl: RTL and testbench

JPEG_IDCT_TRANSPOSE_CTRL -- requirements
Module: jpeg_idct_transpose_ctrl

---
 rtl/jpeg_idct_transpose_ctrl.sv | 102 ++++++++++
 tb/tb_jpeg_idct_transpose_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_idct_transpose_ctrl.sv
// Double-buffered 4x4 transpose controller between IDCT row and column passes.
// Writer fills one 16-word bank while the reader drains the other in transposed order.
module jpeg_idct_transpose_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_valid_i,
  input  logic [31:0] inport_data_i,
  output logic        inport_accept_o,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  input  logic        outport_accept_i,
  output logic [4:0]  ram_addr0_o,
  output logic [31:0] ram_data0_o,
  output logic        ram_wr0_o,
  output logic [4:0]  ram_addr1_o,
  input  logic [31:0] ram_data1_i,
  output logic        idle_o
);

  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] bank_full_q, bank_full_d;
  logic [3:0] wr_idx_q, wr_idx_d;
  logic [3:0] rd_idx_q, rd_idx_d;
  logic       rd_done_q, rd_done_d;
  logic       valid_q, valid_d;

  logic       wr_fire;
  logic       out_fire;
  logic       last_acc;
  logic       cur_bank;
  logic       cur_done;
  logic       issue;
  logic [3:0] pres_idx;

  assign inport_accept_o = ~bank_full_q[wr_bank_q];
  assign ram_wr0_o       = wr_fire;
  assign ram_addr0_o     = {wr_bank_q, wr_idx_q};
  assign ram_data0_o     = inport_data_i;
  assign outport_valid_o = valid_q;
  assign outport_data_o  = ram_data1_i;
  assign idle_o          = ~bank_full_q[0] & ~bank_full_q[1]
                         & ~valid_q & (wr_idx_q == 4'd0);

  // Accepting word 15 hands over to the other bank in the same cycle,
  // so a full next bank streams without a bubble.
  always_comb begin
    wr_fire  = inport_valid_i & inport_accept_o;
    out_fire = valid_q & outport_accept_i;
    last_acc = out_fire & rd_done_q;
    cur_bank = rd_bank_q ^ last_acc;
    cur_done = rd_done_q & ~last_acc;
    issue    = bank_full_q[cur_bank] & ~cur_done
             & (~valid_q | outport_accept_i);
    pres_idx = rd_idx_q - 4'd1;
  end

  // Stalled word keeps its address so the registered RAM output holds.
  always_comb begin
    ram_addr1_o = {rd_bank_q, pres_idx[1:0], pres_idx[3:2]};
    if (issue) begin
      ram_addr1_o = {cur_bank, rd_idx_q[1:0], rd_idx_q[3:2]};
    end
  end

  always_comb begin
    wr_idx_d    = wr_idx_q + {3'd0, wr_fire};
    wr_bank_d   = wr_bank_q ^ (wr_fire & (wr_idx_q == 4'd15));
    bank_full_d = bank_full_q;
    if (last_acc) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
    if (wr_fire && (wr_idx_q == 4'd15)) begin
      bank_full_d[wr_bank_q] = 1'b1;
    end
    rd_idx_d  = rd_idx_q + {3'd0, issue};
    rd_done_d = cur_done | (issue & (rd_idx_q == 4'd15));
    rd_bank_d = cur_bank;
    valid_d   = issue | (valid_q & ~outport_accept_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      wr_idx_q    <= 4'd0;
      rd_idx_q    <= 4'd0;
      rd_done_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bank_full_q <= bank_full_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      rd_done_q   <= rd_done_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_jpeg_idct_transpose_ctrl.sv
// Bench for jpeg_idct_transpose_ctrl: directed scenarios plus random stalls,
// outputs scored against a 4x4 matrix transpose of each 16-word block.
module tb_jpeg_idct_transpose_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_acc;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_acc;
  logic [4:0]  a0;
  logic [31:0] d0;
  logic        w0;
  logic [4:0]  a1;
  logic [31:0] d1;
  logic        idle;

  logic [31:0] mem [32];
  logic [31:0] blk [$];
  logic [31:0] expq [$];
  int total = 0;
  int bad = 0;
  int n_in = 0;
  int n_out = 0;
  localparam int NBLK = 250;

  jpeg_idct_transpose_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .inport_valid_i(in_valid), .inport_data_i(in_data),
    .inport_accept_o(in_acc),
    .outport_valid_o(out_valid), .outport_data_o(out_data),
    .outport_accept_i(out_acc),
    .ram_addr0_o(a0), .ram_data0_o(d0), .ram_wr0_o(w0),
    .ram_addr1_o(a1), .ram_data1_i(d1),
    .idle_o(idle)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // read-first RAM with a registered read port
  always @(posedge clk) begin
    if (w0) mem[a0] <= d0;
    d1 <= mem[a1];
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, o, e);
    end
  endtask

  // block of words w[4r+c] is emitted column-major: out[4c+r] = w[4r+c]
  always @(negedge clk) begin
    if (rst) begin
      blk.delete();
      expq.delete();
    end else begin
      if (in_valid && in_acc) begin
        blk.push_back(in_data);
        n_in++;
        if (blk.size() == 16) begin
          for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
              expq.push_back(blk[4*r+c]);
          blk.delete();
        end
      end
      if (out_valid && out_acc) begin
        n_out++;
        if (expq.size() == 0) chk("unexpected_out", 32'(out_valid), 0);
        else chk("out_order", out_data, expq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_acc = 0; in_data = 0;
    step();
    rst = 0;
  endtask

  task automatic drain(input string tag);
    in_valid = 0;
    out_acc = 1;
    for (int c = 0; c < 80 && (expq.size() != 0 || out_valid); c++)
      step();
    #1;
    chk(tag, 32'(expq.size() == 0 && !out_valid), 1);
    chk({tag, "_idle"}, 32'(idle), 1);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = 0; out_acc = 0;
    #1;
    chk("rst_idle", 32'(idle), 1);
    chk("rst_acc", 32'(in_acc), 1);
    chk("rst_wr0", 32'(w0), 0);
    chk("rst_oval", 32'(out_valid), 0);
    step();
    rst = 0;

    // one block, data = index, consumer always ready
    out_acc = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_data = i;
      #1;
      chk("blk_wr_addr", 32'(a0), 32'(i));
      step();
    end
    in_valid = 0;
    #1;
    chk("lat_not_yet", 32'(out_valid), 0);
    step();
    #1;
    chk("lat_first_valid", 32'(out_valid), 1);
    chk("lat_first_data", out_data, 0);
    drain("blk_drain");

    // stall on the fourth emitted word (value 12 at index 12)
    do_reset();
    out_acc = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_data = i;
      step();
    end
    in_valid = 0;
    for (int c = 0; c < 10 && !out_valid; c++) step();
    chk("stall_wait", 32'(out_valid), 1);
    for (int k = 0; k < 3; k++) step();
    out_acc = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_data", out_data, 12);
      chk("stall_addr", 32'(a1), 32'h0c);
      chk("stall_valid", 32'(out_valid), 1);
      step();
    end
    drain("stall_drain");

    // both banks full with consumer blocked
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 32; i++) begin
      in_data = $urandom;
      #1;
      chk("fill_acc", 32'(in_acc), 1);
      step();
    end
    #1;
    chk("full_acc33", 32'(in_acc), 0);
    out_acc = 1;
    for (int k = 0; k < 16; k++) begin
      chk("full_hold", 32'(in_acc), 0);
      step();
      #1;
    end
    chk("full_release", 32'(in_acc), 1);
    in_valid = 0;
    drain("full_drain");

    // reset in the middle of traffic
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 23; i++) begin
      in_data = $urandom;
      step();
    end
    in_valid = 0;
    out_acc = 1;
    for (int k = 0; k < 3; k++) step();
    out_acc = 0;
    rst = 1;
    #1;
    chk("mid_rst_oval", 32'(out_valid), 0);
    chk("mid_rst_acc", 32'(in_acc), 1);
    chk("mid_rst_idle", 32'(idle), 1);
    chk("mid_rst_wr0", 32'(w0), 0);
    step();
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_data = $urandom;
      #1;
      chk("post_rst_addr", 32'(a0), 32'(i));
      chk("post_rst_wr0", 32'(w0), 1);
      step();
    end
    drain("post_rst_drain");

    // random valid/accept stalls across many blocks
    do_reset();
    n_in = 0;
    n_out = 0;
    for (int c = 0; c < 40000; c++) begin
      if (n_in >= NBLK * 16 && expq.size() == 0 && !out_valid) break;
      in_valid = (n_in < NBLK * 16) && ($urandom % 4 != 0);
      in_data = $urandom;
      out_acc = ($urandom % 3 != 0);
      step();
    end
    in_valid = 0;
    out_acc = 0;
    #1;
    chk("rand_words_in", 32'(n_in), 32'(NBLK * 16));
    chk("rand_words_out", 32'(n_out), 32'(NBLK * 16));
    chk("rand_pending", 32'(expq.size()), 0);
    chk("rand_idle", 32'(idle), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
